cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_ctrl_instr_dec.sv | 64 ++++++
 rtl/cpu_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu_ctrl controller.
//   state_t      - controller FSM states
//   instr_cls_t  - decoded instruction class
//   OPC_* / OP_* - opcode ([15:13]) and op ([12:11]) field values
//   ALU_*        - ALU_op output encodings
//   WB_*         - wb_sel output encodings
//   sext8()      - sign-extend an 8-bit immediate to the 16-bit datapath
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_GET_A  = 3'd1,
        S_GET_B  = 3'd2,
        S_CALC   = 3'd3,
        S_WR_REG = 3'd4,
        S_WR_IMM = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_MOV_IMM = 3'd0,
        CLS_MOV_REG = 3'd1,
        CLS_ADD     = 3'd2,
        CLS_CMP     = 3'd3,
        CLS_AND     = 3'd4,
        CLS_MVN     = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_cls_t;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_AND   = 2'b10;
    localparam logic [1:0] ALU_NOT_B = 2'b11;

    localparam logic [1:0] WB_C   = 2'b00;
    localparam logic [1:0] WB_IMM = 2'b10;

    function automatic logic [15:0] sext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/cpu_ctrl_instr_dec.sv
// instr_dec: purely combinational decode of an instruction word.
//   ir      in  16  instruction word
//   rn      out 3   ir[10:8]
//   rd      out 3   ir[7:5]
//   rm      out 3   ir[2:0]
//   shift   out 2   ir[4:3]
//   sximm8  out 16  ir[7:0] sign-extended
//   cls     out 3   instruction class (instr_cls_t)
//   illegal out 1   word is not a defined instruction
module instr_dec
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [2:0]  rm,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output instr_cls_t  cls,
    output logic        illegal
);

    logic [2:0] opcode;
    logic [1:0] op;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign shift  = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = sext8(ir[7:0]);

    always_comb begin
        cls     = CLS_ILLEGAL;
        illegal = 1'b1;
        case (opcode)
            OPC_ALU: begin
                illegal = 1'b0;
                case (op)
                    OP_ADD:  cls = CLS_ADD;
                    OP_CMP:  cls = CLS_CMP;
                    OP_AND:  cls = CLS_AND;
                    default: cls = CLS_MVN;
                endcase
            end
            OPC_MOV: begin
                // Only MOV imm and MOV reg exist; the other two op codes stay illegal.
                if (op == OP_MOV_IMM) begin
                    cls     = CLS_MOV_IMM;
                    illegal = 1'b0;
                end else if (op == OP_MOV_REG) begin
                    cls     = CLS_MOV_REG;
                    illegal = 1'b0;
                end
            end
            default: begin
                cls     = CLS_ILLEGAL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle controller for a 16-bit, 8-register datapath.
//   clk, rst        clock, synchronous active-high reset
//   start, instr    execute request and the instruction to execute
//   ZNV             ALU flags {Z,N,V} from the current A/B registers
//   waiting         controller idle in WAIT
//   r_addr, en_A, en_B           register read / operand load
//   sel_A, shift_op, ALU_op, en_C  ALU control and result load
//   w_addr, w_en, wb_sel, sximm8   register write-back
//   status          latched {Z,N,V} from the last CMP
//   err             last accepted instruction was undefined
//
// Handshake: waiting acts as ready. start is a one-cycle request that is
// accepted only on an edge where the controller is in WAIT (waiting=1);
// start in any other state is dropped, and instr is captured into IR at
// acceptance so later changes on instr have no effect.
//
// All control outputs are registers: the always_comb computes the next state
// and then the outputs belonging to that next state, so each output is valid
// for the whole cycle the FSM spends in the named state. The decoder looks at
// ir_d so the outputs of the first post-accept state come from the new word.
module cpu_ctrl
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic [2:0]  ZNV,
    output logic        waiting,
    output logic [2:0]  r_addr,
    output logic        en_A,
    output logic        en_B,
    output logic        sel_A,
    output logic [1:0]  shift_op,
    output logic [1:0]  ALU_op,
    output logic        en_C,
    output logic [2:0]  w_addr,
    output logic        w_en,
    output logic [1:0]  wb_sel,
    output logic [15:0] sximm8,
    output logic [2:0]  status,
    output logic        err
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  status_q, status_d;
    logic        err_q, err_d;
    logic        waiting_q, waiting_d;
    logic [2:0]  r_addr_q, r_addr_d;
    logic        en_a_q, en_a_d;
    logic        en_b_q, en_b_d;
    logic        sel_a_q, sel_a_d;
    logic [1:0]  shift_op_q, shift_op_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic        en_c_q, en_c_d;
    logic [2:0]  w_addr_q, w_addr_d;
    logic        w_en_q, w_en_d;
    logic [1:0]  wb_sel_q, wb_sel_d;
    logic [15:0] sximm8_q, sximm8_d;

    logic [2:0]  dec_rn, dec_rd, dec_rm;
    logic [1:0]  dec_shift;
    logic [15:0] dec_sximm8;
    instr_cls_t  dec_cls;
    logic        dec_illegal;

    // IR capture kept apart from the main block so the decoder feeding the
    // next-state logic does not form a loop through the same process.
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && start) begin
            ir_d = instr;
        end
    end

    instr_dec u_dec (
        .ir      (ir_d),
        .rn      (dec_rn),
        .rd      (dec_rd),
        .rm      (dec_rm),
        .shift   (dec_shift),
        .sximm8  (dec_sximm8),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        err_d      = err_q;
        waiting_d  = 1'b0;
        r_addr_d   = 3'd0;
        en_a_d     = 1'b0;
        en_b_d     = 1'b0;
        sel_a_d    = 1'b0;
        shift_op_d = 2'b00;
        alu_op_d   = ALU_ADD;
        en_c_d     = 1'b0;
        w_addr_d   = 3'd0;
        w_en_d     = 1'b0;
        wb_sel_d   = WB_C;
        sximm8_d   = dec_sximm8;

        case (state_q)
            S_WAIT: begin
                if (start) begin
                    err_d = dec_illegal;
                    case (dec_cls)
                        CLS_MOV_IMM:          state_d = S_WR_IMM;
                        CLS_MOV_REG, CLS_MVN: state_d = S_GET_B;
                        CLS_ADD, CLS_AND,
                        CLS_CMP:              state_d = S_GET_A;
                        default:              state_d = S_WAIT;
                    endcase
                end
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: state_d = S_CALC;
            S_CALC: begin
                // CMP only updates flags; everything else writes its result back.
                if (dec_cls == CLS_CMP) begin
                    status_d = ZNV;
                    state_d  = S_WAIT;
                end else begin
                    state_d  = S_WR_REG;
                end
            end
            default: state_d = S_WAIT;
        endcase

        case (state_d)
            S_WAIT: waiting_d = 1'b1;
            S_GET_A: begin
                r_addr_d = dec_rn;
                en_a_d   = 1'b1;
            end
            S_GET_B: begin
                r_addr_d = dec_rm;
                en_b_d   = 1'b1;
            end
            S_CALC: begin
                en_c_d     = 1'b1;
                shift_op_d = dec_shift;
                case (dec_cls)
                    CLS_MOV_REG: begin
                        // MOV reg is 0 + shifted Rm.
                        sel_a_d  = 1'b1;
                        alu_op_d = ALU_ADD;
                    end
                    CLS_CMP: alu_op_d = ALU_SUB;
                    CLS_AND: alu_op_d = ALU_AND;
                    CLS_MVN: alu_op_d = ALU_NOT_B;
                    default: alu_op_d = ALU_ADD;
                endcase
            end
            S_WR_REG: begin
                w_addr_d = dec_rd;
                w_en_d   = 1'b1;
                wb_sel_d = WB_C;
            end
            S_WR_IMM: begin
                w_addr_d = dec_rn;
                w_en_d   = 1'b1;
                wb_sel_d = WB_IMM;
            end
            default: waiting_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_WAIT;
            ir_q       <= 16'h0000;
            status_q   <= 3'b000;
            err_q      <= 1'b0;
            waiting_q  <= 1'b1;
            r_addr_q   <= 3'd0;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            sel_a_q    <= 1'b0;
            shift_op_q <= 2'b00;
            alu_op_q   <= ALU_ADD;
            en_c_q     <= 1'b0;
            w_addr_q   <= 3'd0;
            w_en_q     <= 1'b0;
            wb_sel_q   <= WB_C;
            sximm8_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            status_q   <= status_d;
            err_q      <= err_d;
            waiting_q  <= waiting_d;
            r_addr_q   <= r_addr_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            sel_a_q    <= sel_a_d;
            shift_op_q <= shift_op_d;
            alu_op_q   <= alu_op_d;
            en_c_q     <= en_c_d;
            w_addr_q   <= w_addr_d;
            w_en_q     <= w_en_d;
            wb_sel_q   <= wb_sel_d;
            sximm8_q   <= sximm8_d;
        end
    end

    assign waiting  = waiting_q;
    assign r_addr   = r_addr_q;
    assign en_A     = en_a_q;
    assign en_B     = en_b_q;
    assign sel_A    = sel_a_q;
    assign shift_op = shift_op_q;
    assign ALU_op   = alu_op_q;
    assign en_C     = en_c_q;
    assign w_addr   = w_addr_q;
    assign w_en     = w_en_q;
    assign wb_sel   = wb_sel_q;
    assign sximm8   = sximm8_q;
    assign status   = status_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: randomized self-checking bench for cpu_ctrl.
// The driver walks each instruction through a phase list taken from the
// instruction table and pushes the expected output vector of every cycle into
// exp_q; the monitor pops one entry per cycle and compares it with the DUT.
module tb_cpu_ctrl;

    localparam int EW = 38;

    typedef enum int {P_WAIT, P_A, P_B, P_C, P_WR, P_IMM} phase_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] instr;
    logic [2:0]  ZNV;
    logic        waiting;
    logic [2:0]  r_addr;
    logic        en_A, en_B, sel_A, en_C, w_en, err;
    logic [1:0]  shift_op, ALU_op, wb_sel;
    logic [2:0]  w_addr, status;
    logic [15:0] sximm8;

    cpu_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .instr    (instr),
        .ZNV      (ZNV),
        .waiting  (waiting),
        .r_addr   (r_addr),
        .en_A     (en_A),
        .en_B     (en_B),
        .sel_A    (sel_A),
        .shift_op (shift_op),
        .ALU_op   (ALU_op),
        .en_C     (en_C),
        .w_addr   (w_addr),
        .w_en     (w_en),
        .wb_sel   (wb_sel),
        .sximm8   (sximm8),
        .status   (status),
        .err      (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [EW-1:0] dut_vec;
    assign dut_vec = {waiting, r_addr, en_A, en_B, sel_A, shift_op, ALU_op, en_C,
                      w_addr, w_en, wb_sel, sximm8, status, err};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++;
                $display("FAIL ctrl_vec #%0d t=%0t: got %h expected %h (waiting r_addr enA enB selA shift alu enC w_addr w_en wb_sel sximm8 status err)",
                         checks, $time, dut_vec, e);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [2:0]  m_status;
    logic        m_err;
    logic [15:0] m_sx;
    phase_t      path_q[$];

    function automatic logic [15:0] to_sx(input logic [15:0] ins);
        int v;
        v = int'(ins[7:0]);
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    // Phase sequence after acceptance, ending with the return to WAIT.
    function automatic bit build_path(input logic [15:0] ins);
        logic [4:0] key;
        key = ins[15:11];
        path_q.delete();
        case (key)
            5'b110_10: path_q = '{P_IMM, P_WAIT};
            5'b110_00: path_q = '{P_B, P_C, P_WR, P_WAIT};
            5'b101_00: path_q = '{P_A, P_B, P_C, P_WR, P_WAIT};
            5'b101_10: path_q = '{P_A, P_B, P_C, P_WR, P_WAIT};
            5'b101_01: path_q = '{P_A, P_B, P_C, P_WAIT};
            5'b101_11: path_q = '{P_B, P_C, P_WR, P_WAIT};
            default: begin
                path_q = '{P_WAIT};
                return 1'b0;
            end
        endcase
        return 1'b1;
    endfunction

    function automatic logic [EW-1:0] exp_vec(input phase_t p, input logic [15:0] ins);
        logic       w, ea, eb, sa, ec, we;
        logic [2:0] ra, wa;
        logic [1:0] sh, alu, wb;
        w = 0; ea = 0; eb = 0; sa = 0; ec = 0; we = 0;
        ra = 0; wa = 0; sh = 0; alu = 0; wb = 0;
        case (p)
            P_WAIT: w = 1;
            P_A: begin ra = ins[10:8]; ea = 1; end
            P_B: begin ra = ins[2:0]; eb = 1; end
            P_C: begin
                ec = 1;
                sh = ins[4:3];
                if (ins[15:13] == 3'b110) begin sa = 1; alu = 2'b00; end
                else alu = ins[12:11];
            end
            P_WR:  begin wa = ins[7:5]; we = 1; wb = 2'b00; end
            P_IMM: begin wa = ins[10:8]; we = 1; wb = 2'b10; end
            default: w = 0;
        endcase
        return {w, ra, ea, eb, sa, sh, alu, ec, wa, we, wb, m_sx, m_status, m_err};
    endfunction

    // ---------------- driver ----------------
    // Drive one cycle's inputs, take the edge, then queue what the DUT must
    // show for the cycle just entered.
    task automatic tick(input logic st, input logic [15:0] in, input logic [2:0] z,
                        input logic r, input phase_t p, input logic [15:0] ins);
        #1;
        start = st;
        instr = in;
        ZNV   = z;
        rst   = r;
        @(posedge clk);
        exp_q.push_back(exp_vec(p, ins));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            m_status = 3'b000;
            m_err    = 1'b0;
            m_sx     = 16'h0000;
            tick(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)), 1'b1, P_WAIT, 16'h0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 16'($urandom), 3'($urandom_range(0, 7)), 1'b0, P_WAIT, 16'h0);
        end
    endtask

    // force_z >= 0 fixes ZNV during CALC; rst_at > 0 asserts rst during that
    // post-accept cycle (1 = first cycle after acceptance).
    task automatic run_instr(input logic [15:0] ins, input int force_z, input int rst_at);
        bit     legal;
        bit     is_cmp;
        phase_t cur;
        logic [2:0] z;
        logic   st;
        legal  = build_path(ins);
        is_cmp = (ins[15:11] == 5'b101_01);
        m_err  = !legal;
        m_sx   = to_sx(ins);
        tick(1'b1, ins, 3'($urandom_range(0, 7)), 1'b0, path_q[0], ins);
        for (int k = 1; k < path_q.size(); k++) begin
            cur = path_q[k-1];
            z   = (cur == P_C && force_z >= 0) ? 3'(force_z) : 3'($urandom_range(0, 7));
            // start outside WAIT must be ignored: always poke it in GET_B.
            st  = (cur == P_B) ? 1'b1 : 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                m_status = 3'b000;
                m_err    = 1'b0;
                m_sx     = 16'h0000;
                tick(st, 16'($urandom), z, 1'b1, P_WAIT, 16'h0);
                return;
            end
            if (cur == P_C && is_cmp) m_status = z;
            tick(st, 16'($urandom), z, 1'b0, path_q[k], ins);
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] v;
        int sel;
        v   = 16'($urandom);
        sel = $urandom_range(0, 9);
        if (sel < 4)      v[15:13] = 3'b101;
        else if (sel < 8) v[15:13] = 3'b110;
        return v;
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        instr = 16'h0000;
        ZNV   = 3'b000;
        m_status = 3'b000;
        m_err    = 1'b0;
        m_sx     = 16'h0000;
        @(posedge clk);
        do_reset(2);
        idle(2);

        run_instr(16'hD0FB, -1, 0);     // MOV R0,#-5
        run_instr(16'hA140, -1, 0);     // ADD R2,R1,R0
        run_instr(16'hA900, 4, 0);      // CMP R1,R0 with ZNV=100
        idle(1);
        run_instr(16'hC069, -1, 0);     // MOV R3,R1,LSL#1
        run_instr(16'hE000, -1, 0);     // undefined
        idle(1);
        run_instr(16'hD87F, -1, 0);     // opcode 110 op 11: undefined
        run_instr(16'hB8F7, -1, 0);     // MVN
        run_instr(16'hB25A, -1, 0);     // AND
        run_instr(16'hA900, 2, 0);      // CMP with ZNV=010
        run_instr(16'hA140, -1, 2);     // ADD, reset while in GET_B
        idle(2);
        run_instr(16'hE000, -1, 0);
        run_instr(16'hA900, 1, 0);

        for (int n = 0; n < 200; n++) begin
            logic [15:0] ins;
            int ra;
            ins = rand_instr();
            ra  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            run_instr(ins, -1, ra);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
